// File: rtl/ranging_pkg.sv
// Shared types and constants for the ultrasonic ranging sequencer.
package ranging_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam int BCD_DIGITS = 3;
  localparam logic [4*BCD_DIGITS-1:0] BCD_MAX = 12'h999;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit saturating BCD counter with synchronous clear.
module bcd_counter3
  import ranging_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [4*BCD_DIGITS-1:0] val_o,
  output logic                    at_max_o
);

  logic [4*BCD_DIGITS-1:0] val_q, val_d;
  logic carry;

  assign val_o    = val_q;
  assign at_max_o = (val_q == BCD_MAX);

  always_comb begin
    val_d = val_q;
    carry = inc_i & ~at_max_o;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (val_q[4*i+:4] == 4'd9) begin
          val_d[4*i+:4] = 4'd0;
        end else begin
          val_d[4*i+:4] = val_q[4*i+:4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr_i) val_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) val_q <= '0;
    else         val_q <= val_d;
  end

endmodule

// File: rtl/ranging_sequencer.sv
// Single-clock trigger / echo-timing / holdoff sequencer for the
// ultrasonic ranger, producing a latched 3-digit BCD distance.
module ranging_sequencer
  import ranging_pkg::*;
#(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TICK_CYCLES    = 5882,
  parameter int WAIT_CYCLES    = 2000000,
  parameter int HOLDOFF_CYCLES = 6000000
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_mode,
  input  logic        echo,
  output logic        stimulus,
  output logic        busy,
  output logic [11:0] dist_bcd,
  output logic        dist_valid,
  output logic        overrange,
  output logic        no_echo
);

  localparam int MAXC = max2(max2(TRIG_CYCLES, TICK_CYCLES),
                             max2(WAIT_CYCLES, HOLDOFF_CYCLES));
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
  // The rise-detect cycle is the first echo-high clock of the window.
  localparam logic [CW-1:0] MEAS_START = CW'((TICK_CYCLES > 1) ? 1 : 0);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] sync_q;
  logic rise, fall;
  logic bcd_clr, bcd_inc, bcd_max;
  logic [11:0] bcd_val;
  logic [11:0] dist_q, dist_d;
  logic valid_q, valid_d;
  logic ovr_q, ovr_d;
  logic noe_q, noe_d;
  logic stim_q, busy_q;

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

  bcd_counter3 u_bcd (
    .clk_i   (system_clk),
    .rst_ni  (reset),
    .clr_i   (bcd_clr),
    .inc_i   (bcd_inc),
    .val_o   (bcd_val),
    .at_max_o(bcd_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bcd_clr = 1'b0;
    bcd_inc = 1'b0;
    dist_d  = dist_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    noe_d   = noe_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start || auto_mode) state_d = TRIG;
      end
      TRIG: begin
        bcd_clr = 1'b1;
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = MEAS_START;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          noe_d   = 1'b1;
          ovr_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          dist_d  = bcd_val;
          noe_d   = 1'b0;
          ovr_d   = 1'b0;
          valid_d = 1'b1;
        end else if (cnt_q == TICK_LAST) begin
          cnt_d = '0;
          if (bcd_max) begin
            state_d = HOLDOFF;
            dist_d  = BCD_MAX;
            noe_d   = 1'b0;
            ovr_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            bcd_inc = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync_q  <= '0;
      dist_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      noe_q   <= 1'b0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[1:0], echo};
      dist_q  <= dist_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      noe_q   <= noe_d;
      stim_q  <= (state_d == TRIG);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign stimulus   = stim_q;
  assign busy       = busy_q;
  assign dist_bcd   = dist_q;
  assign dist_valid = valid_q;
  assign overrange  = ovr_q;
  assign no_echo    = noe_q;

endmodule
